// File: rtl/pipelined_op_decoder.sv
// Registered opcode decoder with valid/ready handshake, illegal-op flagging and post-mul/div issue stall.
// Optional performance counters are enabled with `define DECODER_PERF_EN.
module pipelined_op_decoder #(
    parameter  int                       OPCODE_W     = 3,
    localparam int                       CTRL_W       = 2**OPCODE_W,
    parameter  logic [2**OPCODE_W-1:0]   LEGAL_MASK   = 'h0F,
    parameter  logic [2**OPCODE_W-1:0]   MULTI_MASK   = 'h0C,
    parameter  int                       MULTI_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTRL_W-1:0]   control_signal,
    output logic [OPCODE_W-1:0] decoded_opcode,
    output logic                illegal,
    output logic                busy
`ifdef DECODER_PERF_EN
    ,
    output logic [15:0]         issue_count,
    output logic [15:0]         illegal_count
`endif
);

    localparam bit STALL_EN = (MULTI_CYCLES > 0);
    localparam int CNT_W    = (MULTI_CYCLES < 1) ? 1 : $clog2(MULTI_CYCLES + 1);

    typedef enum logic [1:0] {EMPTY, FULL, HOLD} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   hold_cnt;
    logic               held_multi;
    logic               load;
    logic               out_hs;

    // Only a legal multi-cycle op stalls the ALU; illegal ops pass straight through.
    assign held_multi = STALL_EN && MULTI_MASK[decoded_opcode] && !illegal;
    assign load       = in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            EMPTY: if (in_valid) state_next = FULL;
            FULL: begin
                if (out_ready) begin
                    if (held_multi)    state_next = HOLD;
                    else if (in_valid) state_next = FULL;
                    else               state_next = EMPTY;
                end
            end
            HOLD:    if (hold_cnt <= CNT_W'(1)) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
        if (flush) state_next = EMPTY;
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = (state == FULL);
        busy      = (state == HOLD);
        unique case (state)
            EMPTY:   in_ready = 1'b1;
            FULL:    in_ready = out_ready && !held_multi;
            default: in_ready = 1'b0;
        endcase
        if (flush) in_ready = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (flush) begin
            hold_cnt <= '0;
        end else if (state == FULL && out_ready && held_multi) begin
            hold_cnt <= CNT_W'(MULTI_CYCLES);
        end else if (state == HOLD) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            control_signal <= '0;
            decoded_opcode <= '0;
            illegal        <= 1'b0;
        end else if (flush) begin
            control_signal <= '0;
            illegal        <= 1'b0;
        end else if (load) begin
            control_signal <= LEGAL_MASK[in_opcode] ? (CTRL_W'(1) << in_opcode) : '0;
            decoded_opcode <= in_opcode;
            illegal        <= !LEGAL_MASK[in_opcode];
        end
    end

`ifdef DECODER_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_count   <= '0;
            illegal_count <= '0;
        end else if (out_hs) begin
            if (issue_count != 16'hFFFF)            issue_count   <= issue_count + 16'd1;
            if (illegal && illegal_count != 16'hFFFF) illegal_count <= illegal_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_op_decoder.sv
// Self-checking bench for pipelined_op_decoder: directed test-plan sequences plus randomized traffic
// against a transaction-level reference model.
module tb_pipelined_op_decoder;

    localparam int          OW     = 3;
    localparam int          CW     = 8;
    localparam logic [7:0]  LEGAL  = 8'h0F;
    localparam logic [7:0]  MULTI  = 8'h0C;
    localparam int          MC     = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] in_opcode = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] control_signal;
    logic [OW-1:0] decoded_opcode;
    logic          illegal;
    logic          busy;
`ifdef DECODER_PERF_EN
    logic [15:0]   issue_count;
    logic [15:0]   illegal_count;
`endif

    int total = 0;
    int bad   = 0;

    // reference model: whether an op is presented, remaining stall cycles, presented op attributes
    bit m_have;
    int m_hold;
    int m_op;
    int m_ctrl;
    bit m_ill;
    int m_issue;
    int m_illc;

    pipelined_op_decoder #(
        .OPCODE_W(OW), .LEGAL_MASK(LEGAL), .MULTI_MASK(MULTI), .MULTI_CYCLES(MC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .control_signal(control_signal), .decoded_opcode(decoded_opcode),
        .illegal(illegal), .busy(busy)
`ifdef DECODER_PERF_EN
        , .issue_count(issue_count), .illegal_count(illegal_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_hold = 0; m_op = 0; m_ctrl = 0; m_ill = 0;
        m_issue = 0; m_illc = 0;
    endtask

    task automatic model_load(input int op);
        m_have = 1;
        m_op   = op;
        m_ill  = !LEGAL[op];
        m_ctrl = LEGAL[op] ? (1 << op) : 0;
    endtask

    // Drives one cycle of inputs, checks all outputs, advances the model, then crosses the clock edge.
    task automatic step(input bit v, input int op, input bit rdy, input bit fl);
        bit exp_ready;
        in_valid = v; in_opcode = op[OW-1:0]; out_ready = rdy; flush = fl;
        #1;
        if (fl || m_hold > 0)   exp_ready = 0;
        else if (!m_have)       exp_ready = 1;
        else                    exp_ready = rdy && !(MULTI[m_op] && !m_ill && MC > 0);
        check("out_valid", out_valid, m_have);
        check("busy", busy, m_hold > 0);
        check("in_ready", in_ready, exp_ready);
        check("control", control_signal, m_ctrl);
        check("illegal", illegal, m_ill);
        check("opcode", decoded_opcode, m_op);
`ifdef DECODER_PERF_EN
        check("issue_cnt", issue_count, m_issue);
        check("illegal_cnt", illegal_count, m_illc);
`endif
        if (m_have && rdy) begin
            if (m_issue < 16'hFFFF) m_issue++;
            if (m_ill && m_illc < 16'hFFFF) m_illc++;
        end
        if (fl) begin
            m_have = 0; m_hold = 0; m_ctrl = 0; m_ill = 0;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (!m_have) begin
            if (v) model_load(op);
        end else if (rdy) begin
            if (MULTI[m_op] && !m_ill && MC > 0) begin
                m_have = 0; m_hold = MC;
            end else if (v) begin
                model_load(op);
            end else begin
                m_have = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int busy_cycles;
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_control", control_signal, 0);
        check("rst_busy", busy, 0);

        // single op then drain
        step(1, 0, 1, 0);
        check("op0_control", control_signal, 32'h01);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // back-to-back single-cycle ops
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        check("b2b_control", control_signal, 32'h02);
        step(0, 0, 1, 0);

        // mul and div stalls: count busy cycles after the handshake
        for (int k = 2; k <= 3; k++) begin
            step(1, k, 1, 0);
            step(0, 0, 1, 0);
            busy_cycles = 0;
            for (int c = 0; c < 6; c++) begin
                if (busy) busy_cycles++;
                step(0, 0, 1, 0);
            end
            check("hold_len", busy_cycles, MC);
        end

        // illegal op: presented, flagged, no stall
        step(1, 5, 1, 0);
        check("ill_flag", illegal, 1);
        step(0, 0, 1, 0);
        check("ill_no_hold", busy, 0);

        // back-pressure while holding opcode 1
        step(1, 1, 0, 0);
        for (int c = 0; c < 4; c++) step(1, 3, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // flush in the second stall cycle
        step(1, 2, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 1, 1, 1);
        check("flush_busy", busy, 0);
        step(0, 0, 1, 0);

        // asynchronous reset while FULL
        step(1, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_ctrl", control_signal, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 7),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
